// File: rtl/storage_elm_monitor_if.sv
// storage_elm_monitor_if
//   Bundles the storage-element monitor's control, sample and result signals.
//   master : the side that drives start/win_len/d/q_* and reads the results
//   slave  : the monitor itself
//   Signals: start, win_len[WIN_W], d, q_a, q_b, q_c (master -> slave)
//            busy, done, cnt_ab/cnt_bc/cnt_bd[CNT_W] (slave -> master)
//   STORAGE_MON_STICKY_EN adds err and first_err_cyc[WIN_W] (slave -> master).
interface storage_elm_monitor_if #(
  parameter int CNT_W = 8,
  parameter int WIN_W = 8
);
  logic             start;
  logic [WIN_W-1:0] win_len;
  logic             d;
  logic             q_a;
  logic             q_b;
  logic             q_c;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] cnt_ab;
  logic [CNT_W-1:0] cnt_bc;
  logic [CNT_W-1:0] cnt_bd;
`ifdef STORAGE_MON_STICKY_EN
  logic             err;
  logic [WIN_W-1:0] first_err_cyc;
`endif

  modport master (
    output start, win_len, d, q_a, q_b, q_c,
    input  busy, done, cnt_ab, cnt_bc, cnt_bd
`ifdef STORAGE_MON_STICKY_EN
    , input err, first_err_cyc
`endif
  );

  modport slave (
    input  start, win_len, d, q_a, q_b, q_c,
    output busy, done, cnt_ab, cnt_bc, cnt_bd
`ifdef STORAGE_MON_STICKY_EN
    , output err, first_err_cyc
`endif
  );
endinterface

// File: rtl/storage_elm_monitor.sv
// storage_elm_monitor
//   Consumer end of the storage-element comparison bench. Each rising clk edge
//   inside a measurement window it compares latch (q_a), posedge-FF (q_b) and
//   negedge-FF (q_c) outputs against each other and q_b against d delayed one
//   edge, counting disagreements in saturating counters. Results are frozen
//   and flagged with done when the window ends.
//   Ports: clk, rst (async, active high), bus (storage_elm_monitor_if.slave):
//     start/win_len begin a window of max(win_len,1) samples; busy in RUN;
//     done + cnt_ab/cnt_bc/cnt_bd once the window has completed.
//   Optional: define STORAGE_MON_STICKY_EN to add err/first_err_cyc, a sticky
//   flag and the cycle index of the first failing sample in the window.
module storage_elm_monitor #(
  parameter int CNT_W = 8,
  parameter int WIN_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  storage_elm_monitor_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state, state_nxt;
  logic [WIN_W-1:0] len_q;
  logic [WIN_W-1:0] cyc;
  logic             d_prev;
  logic [CNT_W-1:0] cnt_ab_q, cnt_bc_q, cnt_bd_q;
  logic             load, last;
  logic             mis_ab, mis_bc, mis_bd;

  // start only acts outside RUN; a start during a window is ignored
  assign load   = bus.start && (state != RUN);
  assign last   = (state == RUN) && (cyc == len_q - WIN_W'(1));

  assign mis_ab = bus.q_a ^ bus.q_b;
  assign mis_bc = bus.q_b ^ bus.q_c;
  // d_prev holds stale pre-window data on the first sample, so skip it
  assign mis_bd = (bus.q_b ^ d_prev) && (cyc != '0);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c,
                                               input logic hit);
    return (hit && (c != CNT_MAX)) ? c + CNT_W'(1) : c;
  endfunction

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (last)      state_nxt = DONE;
      DONE:    if (bus.start) state_nxt = RUN;
      default:                state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) d_prev <= 1'b0;
    else     d_prev <= bus.d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q    <= '0;
      cyc      <= '0;
      cnt_ab_q <= '0;
      cnt_bc_q <= '0;
      cnt_bd_q <= '0;
    end else if (load) begin
      // a zero-length request still takes one sample
      len_q    <= (bus.win_len == '0) ? WIN_W'(1) : bus.win_len;
      cyc      <= '0;
      cnt_ab_q <= '0;
      cnt_bc_q <= '0;
      cnt_bd_q <= '0;
    end else if (state == RUN) begin
      cyc      <= cyc + WIN_W'(1);
      cnt_ab_q <= sat_inc(cnt_ab_q, mis_ab);
      cnt_bc_q <= sat_inc(cnt_bc_q, mis_bc);
      cnt_bd_q <= sat_inc(cnt_bd_q, mis_bd);
    end
  end

  assign bus.busy   = (state == RUN);
  assign bus.done   = (state == DONE);
  assign bus.cnt_ab = cnt_ab_q;
  assign bus.cnt_bc = cnt_bc_q;
  assign bus.cnt_bd = cnt_bd_q;

`ifdef STORAGE_MON_STICKY_EN
  logic             err_q;
  logic [WIN_W-1:0] ferr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q  <= 1'b0;
      ferr_q <= '0;
    end else if (load) begin
      err_q  <= 1'b0;
      ferr_q <= '0;
    end else if ((state == RUN) && !err_q && (mis_ab || mis_bc || mis_bd)) begin
      err_q  <= 1'b1;
      ferr_q <= cyc;
    end
  end

  assign bus.err           = err_q;
  assign bus.first_err_cyc = ferr_q;
`endif
endmodule
